// File: rtl/health_bar_renderer.sv
// Two-stage pixel renderer for the dive/kick health-bar sprites, with per-bar
// frame-synchronous health state and a delayed "damage trail" overlay.
module health_bar_renderer #(
  parameter int BAR_W       = 144,
  parameter int BAR_H       = 12,
  parameter int BAR_Y0      = 16,
  parameter int DIVE_X0     = 40,
  parameter int KICK_X0     = 456,
  parameter int FILL_IDX    = 12,
  parameter int TRAIL_IDX   = 48,
  parameter int HOLD_FRAMES = 30,
  parameter int DRAIN_STEP  = 2
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     frame_clk_rise,
  input  logic [9:0]               DrawX,
  input  logic [9:0]               DrawY,
  input  logic [7:0]               dive_target,
  input  logic [7:0]               kick_target,
  input  logic [BAR_H*BAR_W*6-1:0] dive_health_bar,
  input  logic [BAR_H*BAR_W*6-1:0] kick_health_bar,
  output logic [5:0]               pixel_idx,
  output logic                     pixel_on,
  output logic                     dive_ko,
  output logic                     kick_ko
);

  localparam int PIX_BITS  = 6;
  localparam int SPR_BITS  = BAR_H * BAR_W * PIX_BITS;
  localparam int PIX_W     = $clog2(BAR_H * BAR_W);
  localparam int POS_W     = $clog2(SPR_BITS);
  localparam int ROW_W     = $clog2(BAR_H);
  localparam int COL_W     = $clog2(BAR_W);
  localparam int HP_W      = 8;
  localparam int HOLD_W    = $clog2(HOLD_FRAMES + 1);
  localparam int EMPTY_IDX = 63;

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_DRAIN} bar_state_t;

  // ---------------------------------------------------------------------------
  // Per-bar health state (index 0 = dive, 1 = kick)
  // ---------------------------------------------------------------------------
  bar_state_t        r_state     [2];
  bar_state_t        w_state_nxt [2];
  logic [HP_W-1:0]   r_hp        [2];
  logic [HP_W-1:0]   w_hp_nxt    [2];
  logic [HP_W-1:0]   r_trail     [2];
  logic [HP_W-1:0]   w_trail_nxt [2];
  logic [HOLD_W-1:0] r_hold      [2];
  logic [HOLD_W-1:0] w_hold_nxt  [2];
  logic [HOLD_W-1:0] w_hold_inc  [2];
  logic [HP_W-1:0]   w_raw_tgt   [2];
  logic [HP_W-1:0]   w_target    [2];
  logic [HP_W-1:0]   w_drained   [2];

  assign w_raw_tgt[0] = dive_target;
  assign w_raw_tgt[1] = kick_target;

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      w_target[b]   = (w_raw_tgt[b] > HP_W'(BAR_W)) ? HP_W'(BAR_W) : w_raw_tgt[b];
      w_hold_inc[b] = r_hold[b] + HOLD_W'(1);
      // trail >= hp always holds, so the gap never underflows
      w_drained[b]  = ((r_trail[b] - r_hp[b]) > HP_W'(DRAIN_STEP))
                      ? (r_trail[b] - HP_W'(DRAIN_STEP)) : r_hp[b];
    end
  end

  // NOTE: every output of a combinational block is given a default first so no
  // path through the if/case leaves it unassigned (which would infer a latch).
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      w_state_nxt[b] = r_state[b];
      w_hp_nxt[b]    = r_hp[b];
      w_trail_nxt[b] = r_trail[b];
      w_hold_nxt[b]  = r_hold[b];
      if (frame_clk_rise) begin
        if (w_target[b] < r_hp[b]) begin
          w_hp_nxt[b]    = w_target[b];
          w_hold_nxt[b]  = '0;
          w_state_nxt[b] = S_HOLD;
        end else if (w_target[b] > r_hp[b]) begin
          w_hp_nxt[b]    = w_target[b];
          w_trail_nxt[b] = w_target[b];
          w_hold_nxt[b]  = '0;
          w_state_nxt[b] = S_IDLE;
        end else begin
          case (r_state[b])
            S_HOLD: begin
              w_hold_nxt[b] = w_hold_inc[b];
              if (w_hold_inc[b] >= HOLD_W'(HOLD_FRAMES - 1)) w_state_nxt[b] = S_DRAIN;
            end
            S_DRAIN: begin
              w_trail_nxt[b] = w_drained[b];
              if (w_drained[b] == r_hp[b]) w_state_nxt[b] = S_IDLE;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int b = 0; b < 2; b++) begin
        r_state[b] <= S_IDLE;
        r_hp[b]    <= HP_W'(BAR_W);
        r_trail[b] <= HP_W'(BAR_W);
        r_hold[b]  <= '0;
      end
      dive_ko <= 1'b0;
      kick_ko <= 1'b0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        r_state[b] <= w_state_nxt[b];
        r_hp[b]    <= w_hp_nxt[b];
        r_trail[b] <= w_trail_nxt[b];
        r_hold[b]  <= w_hold_nxt[b];
      end
      dive_ko <= (w_hp_nxt[0] == '0);
      kick_ko <= (w_hp_nxt[1] == '0);
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: hit test and sprite fetch
  // ---------------------------------------------------------------------------
  logic               w_row_in, w_dive_in, w_kick_in;
  logic               w_dive_hit, w_kick_hit, w_hit;
  logic [ROW_W-1:0]   w_row;
  logic [COL_W-1:0]   w_col;
  logic [PIX_W-1:0]   w_pix;
  logic [POS_W-1:0]   w_pos;
  logic [PIX_BITS-1:0] w_dive_s, w_kick_s, w_s;

  // Range compares on the raw coordinates so negative offsets cannot alias.
  assign w_row_in  = ({1'b0, DrawY} >= 11'(BAR_Y0))  && ({1'b0, DrawY} < 11'(BAR_Y0 + BAR_H));
  assign w_dive_in = ({1'b0, DrawX} >= 11'(DIVE_X0)) && ({1'b0, DrawX} < 11'(DIVE_X0 + BAR_W));
  assign w_kick_in = ({1'b0, DrawX} >= 11'(KICK_X0)) && ({1'b0, DrawX} < 11'(KICK_X0 + BAR_W));

  assign w_dive_hit = w_row_in & w_dive_in;
  assign w_kick_hit = w_row_in & w_kick_in & ~w_dive_in;
  assign w_hit      = w_dive_hit | w_kick_hit;

  assign w_row = w_hit ? ROW_W'(DrawY - 10'(BAR_Y0)) : '0;
  assign w_col = w_dive_hit ? COL_W'(DrawX - 10'(DIVE_X0)) :
                 w_kick_hit ? COL_W'(DrawX - 10'(KICK_X0)) : '0;

  // Row 0 col 0 sits in the top bits, so pixel k starts 6*k bits below the MSB.
  assign w_pix    = PIX_W'(w_row) * PIX_W'(BAR_W) + PIX_W'(w_col);
  assign w_pos    = POS_W'(SPR_BITS - PIX_BITS) - POS_W'(w_pix) * POS_W'(PIX_BITS);
  assign w_dive_s = dive_health_bar[w_pos +: PIX_BITS];
  assign w_kick_s = kick_health_bar[w_pos +: PIX_BITS];
  assign w_s      = w_dive_hit ? w_dive_s : w_kick_s;

  logic                r1_hit, r1_kick;
  logic [COL_W-1:0]    r1_col;
  logic [PIX_BITS-1:0] r1_s;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r1_hit  <= 1'b0;
      r1_kick <= 1'b0;
      r1_col  <= '0;
      r1_s    <= '0;
    end else begin
      r1_hit  <= w_hit;
      r1_kick <= w_kick_hit;
      r1_col  <= w_col;
      r1_s    <= w_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: colour selection against the registered (pre-update) bar state
  // ---------------------------------------------------------------------------
  logic [COL_W-1:0]    w_fill_col;
  logic [HP_W-1:0]     w_bar_hp, w_bar_trail;
  logic [PIX_BITS-1:0] w_colour;

  assign w_fill_col  = r1_kick ? (COL_W'(BAR_W - 1) - r1_col) : r1_col;
  assign w_bar_hp    = r1_kick ? r_hp[1]    : r_hp[0];
  assign w_bar_trail = r1_kick ? r_trail[1] : r_trail[0];

  always_comb begin
    w_colour = PIX_BITS'(EMPTY_IDX);
    if (r1_s != PIX_BITS'(EMPTY_IDX))           w_colour = r1_s;
    else if (HP_W'(w_fill_col) < w_bar_hp)      w_colour = PIX_BITS'(FILL_IDX);
    else if (HP_W'(w_fill_col) < w_bar_trail)   w_colour = PIX_BITS'(TRAIL_IDX);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pixel_idx <= '0;
      pixel_on  <= 1'b0;
    end else begin
      pixel_idx <= r1_hit ? w_colour : '0;
      pixel_on  <= r1_hit;
    end
  end

endmodule

// File: tb/tb_health_bar_renderer.sv
// Self-checking bench for health_bar_renderer: boundary vectors, hand-written
// frame sequences and randomized traffic against a frame-level health model.
module tb_health_bar_renderer;

  localparam int W = 144, H = 12, Y0 = 16, DX0 = 40, KX0 = 456;
  localparam int FILL = 12, TRAIL = 48, HOLD = 30, STEP = 2;
  localparam int EMPTY = 63, INK = 61;
  localparam int SB = H * W * 6;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          frame_clk_rise;
  logic [9:0]    DrawX, DrawY;
  logic [7:0]    dive_target, kick_target;
  logic [SB-1:0] dive_health_bar, kick_health_bar;
  logic [5:0]    pixel_idx;
  logic          pixel_on, dive_ko, kick_ko;

  health_bar_renderer dut (
    .Clk(Clk), .Reset(Reset), .frame_clk_rise(frame_clk_rise),
    .DrawX(DrawX), .DrawY(DrawY),
    .dive_target(dive_target), .kick_target(kick_target),
    .dive_health_bar(dive_health_bar), .kick_health_bar(kick_health_bar),
    .pixel_idx(pixel_idx), .pixel_on(pixel_on),
    .dive_ko(dive_ko), .kick_ko(kick_ko)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  int spr [2][H][W];

  // Frame-level model: health, trail, frames elapsed since the last hit.
  int m_hp[2], m_trail[2], m_since[2];
  bit m_hurt[2];

  typedef struct { int idx; int on; int x; int y; } exp_t;
  exp_t pend[$];

  typedef struct { int x; int y; int on; } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int b = 0; b < 2; b++) begin
      m_hp[b] = W; m_trail[b] = W; m_since[b] = 0; m_hurt[b] = 0;
    end
  endfunction

  function automatic void model_frame(input int dt, input int kt);
    int t;
    for (int b = 0; b < 2; b++) begin
      t = (b == 0) ? dt : kt;
      if (t > W) t = W;
      if (t < m_hp[b]) begin
        m_hp[b] = t; m_since[b] = 0; m_hurt[b] = 1;
      end else if (t > m_hp[b]) begin
        m_hp[b] = t; m_trail[b] = t; m_hurt[b] = 0;
      end else if (m_hurt[b]) begin
        m_since[b]++;
        if (m_since[b] >= HOLD)
          m_trail[b] = (m_trail[b] - STEP > m_hp[b]) ? m_trail[b] - STEP : m_hp[b];
      end
    end
  endfunction

  function automatic int model_px(input int x, input int y, output int on);
    int b, c, f, r, s;
    on = 0;
    if (y < Y0 || y >= Y0 + H) return 0;
    r = y - Y0;
    if (x >= DX0 && x < DX0 + W) begin
      b = 0; c = x - DX0; f = c;
    end else if (x >= KX0 && x < KX0 + W) begin
      b = 1; c = x - KX0; f = W - 1 - c;
    end else return 0;
    on = 1;
    s = spr[b][r][c];
    if (s != EMPTY)      return s;
    if (f < m_hp[b])     return FILL;
    if (f < m_trail[b])  return TRAIL;
    return EMPTY;
  endfunction

  // One pixel per clock; the output at each negedge belongs to the pixel
  // driven two negedges earlier.
  task automatic pipe_px(input int x, input int y, input int eidx, input int eon);
    exp_t e;
    @(negedge Clk);
    if (pend.size() == 2) begin
      e = pend.pop_front();
      check($sformatf("px_on(%0d,%0d)", e.x, e.y), int'(pixel_on), e.on);
      check($sformatf("px_idx(%0d,%0d)", e.x, e.y), int'(pixel_idx), e.idx);
    end
    DrawX = 10'(x); DrawY = 10'(y);
    e.idx = eidx; e.on = eon; e.x = x; e.y = y;
    pend.push_back(e);
  endtask

  task automatic scan_px(input int x, input int y);
    int on, idx;
    idx = model_px(x, y, on);
    pipe_px(x, y, idx, on);
  endtask

  task automatic flush();
    pipe_px(0, 0, 0, 0);
    pipe_px(0, 0, 0, 0);
    pend.delete();
  endtask

  task automatic scan_row(input int y);
    for (int x = DX0 - 4; x < DX0 + W + 4; x++) scan_px(x, y);
    for (int x = KX0 - 4; x < KX0 + W + 4; x++) scan_px(x, y);
    flush();
  endtask

  task automatic sample(input int x, input int y, input int eidx, input string name);
    @(negedge Clk);
    DrawX = 10'(x); DrawY = 10'(y);
    @(negedge Clk);
    @(negedge Clk);
    check(name, int'(pixel_idx), eidx);
  endtask

  task automatic frame(input int dt, input int kt);
    @(negedge Clk);
    dive_target = 8'(dt); kick_target = 8'(kt); frame_clk_rise = 1'b1;
    @(negedge Clk);
    frame_clk_rise = 1'b0;
    dive_target = 8'($urandom); kick_target = 8'($urandom);
    model_frame(dt, kt);
    check("dive_ko", int'(dive_ko), int'(m_hp[0] == 0));
    check("kick_ko", int'(kick_ko), int'(m_hp[1] == 0));
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    pend.delete();
  endtask

  function automatic int pick_target(input int hp);
    int r;
    r = $urandom_range(0, 9);
    if (r < 5) return hp;
    if (r < 8) return $urandom_range(0, hp);
    return $urandom_range(0, 255);
  endfunction

  initial begin
    int on, idx, v;

    // Sprites: row 0 left blank so fill/trail are directly visible there.
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++) begin
          v = $urandom_range(0, 9);
          if (r == 0 || v < 7) spr[b][r][c] = EMPTY;
          else if (v < 9)      spr[b][r][c] = INK;
          else                 spr[b][r][c] = $urandom_range(0, 60);
        end
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        dive_health_bar[SB - 1 - 6 * (r * W + c) -: 6] = 6'(spr[0][r][c]);
        kick_health_bar[SB - 1 - 6 * (r * W + c) -: 6] = 6'(spr[1][r][c]);
      end

    Reset = 1'b1; frame_clk_rise = 1'b0;
    DrawX = 10'd100; DrawY = 10'd20;
    dive_target = 8'd144; kick_target = 8'd144;
    model_reset();
    #23;
    check("rst_pixel_on", int'(pixel_on), 0);
    check("rst_pixel_idx", int'(pixel_idx), 0);
    check("rst_dive_ko", int'(dive_ko), 0);
    check("rst_kick_ko", int'(kick_ko), 0);
    @(negedge Clk);
    Reset = 1'b0;

    // Full-health scan, every bar row plus one row of margin each side.
    for (int y = Y0 - 1; y <= Y0 + H; y++) scan_row(y);

    // Boundary vectors.
    vecs = '{
      '{39, 16, 0}, '{40, 16, 1}, '{183, 16, 1}, '{184, 16, 0},
      '{40, 15, 0}, '{40, 27, 1}, '{40, 28, 0}, '{455, 20, 0},
      '{456, 20, 1}, '{599, 20, 1}, '{600, 20, 0}, '{1023, 1023, 0},
      '{0, 0, 0}, '{100, 1000, 0}, '{500, 5, 0}, '{183, 27, 1}
    };
    for (int i = 0; i < vecs.size(); i++) begin
      idx = model_px(vecs[i].x, vecs[i].y, on);
      pipe_px(vecs[i].x, vecs[i].y, vecs[i].on ? idx : 0, vecs[i].on);
    end
    flush();

    // Dive damage 144 -> 100: hold 30 frames, then drain 2/frame.
    frame(100, 144);
    sample(DX0 + 99, 16, FILL, "dive_c99_fill");
    sample(DX0 + 100, 16, TRAIL, "dive_c100_trail");
    for (int i = 1; i < HOLD; i++) begin
      frame(100, 144);
      if (i % 7 == 0) scan_row(16 + i % H);
    end
    sample(DX0 + 143, 16, TRAIL, "trail_held_30");
    frame(100, 144);
    sample(DX0 + 142, 16, EMPTY, "drain1_c142");
    sample(DX0 + 141, 16, TRAIL, "drain1_c141");
    for (int i = 0; i < 21; i++) begin
      frame(100, 144);
      if (i % 5 == 0) scan_row(16 + i % H);
    end
    sample(DX0 + 100, 16, EMPTY, "drained_c100");
    sample(DX0 + 99, 16, FILL, "drained_c99");
    frame(100, 144);
    scan_row(16);

    // Kick bar mirrors: health 10 fills the rightmost 10 columns.
    frame(100, 10);
    sample(590, 16, FILL, "kick_590_fill");
    sample(589, 16, TRAIL, "kick_589_trail");
    sample(599, 16, FILL, "kick_599_fill");
    scan_row(16);
    scan_row(21);
    frame(100, 0);
    sample(599, 16, TRAIL, "kick_ko_trail");

    // Second hit during hold restarts the hold.
    do_reset();
    frame(100, 144);
    for (int i = 1; i < 20; i++) frame(100, 144);
    frame(80, 144);
    for (int i = 0; i < HOLD - 1; i++) frame(80, 144);
    sample(DX0 + 143, 16, TRAIL, "restart_held");
    frame(80, 144);
    sample(DX0 + 143, 16, EMPTY, "restart_drain_c143");
    sample(DX0 + 141, 16, TRAIL, "restart_drain_c141");
    for (int i = 0; i < 32; i++) frame(80, 144);
    sample(DX0 + 80, 16, EMPTY, "restart_done_c80");
    sample(DX0 + 79, 16, FILL, "restart_done_c79");
    scan_row(16);

    // Heal from a draining bar, then an out-of-range target.
    do_reset();
    frame(90, 144);
    for (int i = 0; i < 59; i++) frame(90, 144);
    frame(50, 144);
    for (int i = 0; i < HOLD - 1; i++) frame(50, 144);
    sample(DX0 + 49, 16, FILL, "pre_heal_c49");
    sample(DX0 + 89, 16, TRAIL, "pre_heal_c89");
    sample(DX0 + 90, 16, EMPTY, "pre_heal_c90");
    frame(144, 144);
    sample(DX0 + 143, 16, FILL, "heal_c143");
    scan_row(16);
    frame(200, 200);
    sample(DX0 + 143, 16, FILL, "clamp_c143");
    scan_row(16);

    // Targets moving without a frame pulse must not affect the picture.
    frame(30, 60);
    @(negedge Clk);
    dive_target = 8'd5; kick_target = 8'd0;
    scan_row(16);
    scan_row(18);
    check("no_pulse_dive_ko", int'(dive_ko), 0);
    check("no_pulse_kick_ko", int'(kick_ko), 0);

    // Reset mid-scan clears the pipeline at once and restores full health.
    frame(20, 30);
    @(negedge Clk);
    DrawX = 10'(DX0 + 10); DrawY = 10'd16;
    @(negedge Clk);
    @(negedge Clk);
    check("pre_reset_on", int'(pixel_on), 1);
    #2 Reset = 1'b1;
    #1;
    check("async_reset_on", int'(pixel_on), 0);
    check("async_reset_idx", int'(pixel_idx), 0);
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    pend.delete();
    @(negedge Clk);
    check("post_reset_1clk_on", int'(pixel_on), 0);
    @(negedge Clk);
    check("post_reset_2clk_on", int'(pixel_on), 1);
    check("post_reset_idx", int'(pixel_idx), FILL);
    sample(DX0 + 143, 16, FILL, "post_reset_c143");

    // Randomized frames and pixel bursts.
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        frame(pick_target(m_hp[0]), pick_target(m_hp[1]));
      end else begin
        for (int k = 0; k < 20; k++)
          scan_px($urandom_range(0, 700), $urandom_range(10, 32));
        flush();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/health_bar_renderer.md
Name: health_bar_renderer

Overview:
- Per-pixel consumer of the two 12x144 health-bar sprites (6-bit palette indices; 61 = label ink, 63 = empty slot).
- Overlays live fill and a lagging "damage trail" onto each sprite and emits a palette index for the VGA colour mapper.
- Dive bar fills from the left; kick bar is mirrored and fills from the right.
- Displayed health changes only on frame boundaries, so a bar never tears mid-frame.

Parameters:
- BAR_W, 144, sprite/bar width in pixels; also the maximum health value.
- BAR_H, 12, sprite height in rows.
- BAR_Y0, 16, top screen row of both bars.
- DIVE_X0, 40, left screen column of the dive bar.
- KICK_X0, 456, left screen column of the kick bar.
- FILL_IDX, 12, palette index for live health.
- TRAIL_IDX, 48, palette index for the damage trail.
- HOLD_FRAMES, 30, frames the trail holds before draining.
- DRAIN_STEP, 2, trail pixels removed per frame while draining.

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- frame_clk_rise  in  1  one-cycle pulse at the start of vertical blank
- DrawX  in  10  current pixel column
- DrawY  in  10  current pixel row
- dive_target  in  8  dive health, 0..BAR_W; values >BAR_W are clamped to BAR_W
- kick_target  in  8  kick health, same rules as dive_target
- dive_health_bar  in  12x144x6  packed sprite; row 0 col 0 occupies the most-significant 6 bits, row-major
- kick_health_bar  in  12x144x6  same layout
- pixel_idx  out  6  palette index for (DrawX, DrawY) presented two cycles earlier
- pixel_on  out  1  high when that pixel lies inside either bar
- dive_ko  out  1  high while dive displayed health = 0
- kick_ko  out  1  high while kick displayed health = 0

Behaviour:
- Reset (async, active-high) values:
  - hp_disp = BAR_W and trail = BAR_W for both bars.
  - Both FSMs in IDLE; hold counters = 0.
  - pixel_idx = 0, pixel_on = 0, dive_ko = kick_ko = 0.
  - All pipeline registers cleared.
- Target sampling: targets are sampled only in the cycle frame_clk_rise = 1 and are ignored otherwise.
- Per-bar state update, applied on frame_clk_rise using clamped target t:
  - t < hp_disp: hp_disp <= t (snap down); FSM -> HOLD; hold count <= 0; trail keeps its value.
  - t > hp_disp: hp_disp <= t and trail <= t (heal/round restart snaps both); FSM -> IDLE.
  - t = hp_disp: no change to hp_disp; the FSM acts as below.
- FSM actions, taken on a frame_clk_rise where t = hp_disp:
  - IDLE: no action.
  - HOLD: increment hold count; when count reaches HOLD_FRAMES-1, go to DRAIN.
  - DRAIN: trail <= max(trail - DRAIN_STEP, hp_disp); when the new trail = hp_disp, go to IDLE.
- Invariant: hp_disp <= trail <= BAR_W at all times.
- Fresh damage during HOLD or DRAIN restarts HOLD with count 0; trail is not reset.
- KO outputs: dive_ko and kick_ko are registered, equal to (hp_disp == 0), and update the cycle after frame_clk_rise.
- Pixel pipeline, fixed latency 2, one pixel per clock, no stalls:
  - Stage 1 hit test: row r = DrawY - BAR_Y0 with 0 <= r < BAR_H, and column c = DrawX - DIVE_X0 (or - KICK_X0) with 0 <= c < BAR_W. Out-of-range subtraction must not alias.
  - Stage 1 registers the hit flag, bar select, r, c, and the sprite index s.
  - Stage 2 fill column: dive uses f = c; kick uses f = BAR_W-1-c.
  - Stage 2 colour selection, evaluated in order:
    1. s != 63: output s (label always on top).
    2. f < hp_disp: output FILL_IDX.
    3. f < trail: output TRAIL_IDX.
    4. Otherwise: output 63.
  - No hit: pixel_idx = 0, pixel_on = 0.
- Bar regions never overlap for legal parameters; if they do, dive takes priority.
- frame_clk_rise arriving in the same cycle as a pixel lookup: the pixel uses pre-update state (a registered-state read).
- Reset asserted mid-operation clears the pipeline immediately; pixel_on = 0 until two clocks after deassertion.

Test Plan:
- Reset, then scan DrawY=16..27 across DrawX=40..183 -> pixel_on=1 throughout; slot pixels=FILL_IDX, ink pixels=61; DrawX=39 or 184 -> pixel_on=0; output latency exactly 2 clocks.
- dive_target 144->100, one frame_clk_rise -> dive cols 0..99=FILL_IDX, 100..143=TRAIL_IDX for 30 frames; then trail drains 2/frame, reaching 100 after 22 more frames; FSM back to IDLE.
- kick_target=10 -> kick screen columns 590..599 filled, 456..589 trail/empty (mirrored); kick_target=0 -> kick_ko=1 one cycle after the pulse.
- Damage 144->100, 20 frames later 100->80 -> hold restarts; trail still 144 until frame 50, then drains to 80.
- Heal: from hp=50 trail=90 DRAIN, target=144 -> hp=trail=144, IDLE, no TRAIL_IDX pixels; target=200 -> clamped to 144.
- Targets changed without a frame_clk_rise -> no output change; Reset pulsed mid-scan -> pixel_on=0 immediately, hp restored to 144.
